// File: rtl/flash_load_scheduler.sv
// flash_load_scheduler: wakes the SPI flash after reset, then arbitrates two
// load clients round-robin and programs the flash DMA engine for each grant.
// A watchdog moves the block into a sticky FAULT state on a hung IRQ wait.
module flash_load_scheduler #(
    parameter int unsigned WAKE_ON_RESET  = 1,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'hFFFFFF
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [22:0] req0_flash_addr,
    input  logic [15:0] req0_mem_addr,
    input  logic [15:0] req0_count,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [22:0] req1_flash_addr,
    input  logic [15:0] req1_mem_addr,
    input  logic [15:0] req1_count,
    output logic        done0,
    output logic        done1,
    output logic        busy,
    output logic        fault,
    output logic [3:0]  FL_ADDRESS,
    output logic [15:0] FL_DATA_OUT,
    output logic        FL_WR,
    input  logic        FL_IRQ
);

    localparam logic [3:0] S_WAKE_WR   = 4'd0;
    localparam logic [3:0] S_WAKE_WAIT = 4'd1;
    localparam logic [3:0] S_IDLE      = 4'd2;
    localparam logic [3:0] S_WR_ALO    = 4'd3;
    localparam logic [3:0] S_WR_AHI    = 4'd4;
    localparam logic [3:0] S_WR_DMAA   = 4'd5;
    localparam logic [3:0] S_WR_DMAC   = 4'd6;
    localparam logic [3:0] S_WR_GO     = 4'd7;
    localparam logic [3:0] S_WAIT_IRQ  = 4'd8;
    localparam logic [3:0] S_COMPLETE  = 4'd9;
    localparam logic [3:0] S_FAULT     = 4'd10;
    localparam logic [3:0] S_RESET     = (WAKE_ON_RESET != 0) ? S_WAKE_WR : S_IDLE;

    logic [3:0]  r_state;
    logic [3:0]  w_next_state;
    logic [23:0] r_wdog;
    logic        r_last_grant;
    logic        r_owner;
    logic [22:0] r_flash_addr;
    logic [15:0] r_mem_addr;
    logic [15:0] r_count;
    logic        w_grant_vld;
    logic        w_grant_id;
    logic        w_timeout;
    logic        w_wait_state;

    assign w_wait_state = (r_state == S_WAKE_WAIT) || (r_state == S_WAIT_IRQ);
    assign w_timeout    = (r_wdog == (TIMEOUT_CYCLES - 24'd1));

    // Round-robin grant, only offered while idle and out of reset
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_id  = 1'b0;
        if ((r_state == S_IDLE) && !RST) begin
            if (req0_valid && req1_valid) begin
                w_grant_vld = 1'b1;
                w_grant_id  = ~r_last_grant;
            end else if (req0_valid) begin
                w_grant_vld = 1'b1;
                w_grant_id  = 1'b0;
            end else if (req1_valid) begin
                w_grant_vld = 1'b1;
                w_grant_id  = 1'b1;
            end
        end
    end

    // Next-state decode; an IRQ in the timeout cycle takes priority over FAULT
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_WAKE_WR:   w_next_state = S_WAKE_WAIT;
            S_WAKE_WAIT: begin
                if (FL_IRQ)         w_next_state = S_IDLE;
                else if (w_timeout) w_next_state = S_FAULT;
            end
            S_IDLE:      if (w_grant_vld) w_next_state = S_WR_ALO;
            S_WR_ALO:    w_next_state = S_WR_AHI;
            S_WR_AHI:    w_next_state = S_WR_DMAA;
            S_WR_DMAA:   w_next_state = S_WR_DMAC;
            S_WR_DMAC:   w_next_state = S_WR_GO;
            S_WR_GO:     w_next_state = S_WAIT_IRQ;
            S_WAIT_IRQ: begin
                if (FL_IRQ)         w_next_state = S_COMPLETE;
                else if (w_timeout) w_next_state = S_FAULT;
            end
            S_COMPLETE:  w_next_state = S_IDLE;
            S_FAULT:     w_next_state = S_FAULT;
            default:     w_next_state = S_RESET;
        endcase
    end

    // State register
    always_ff @(posedge CLK) begin
        if (RST) r_state <= S_RESET;
        else     r_state <= w_next_state;
    end

    // Watchdog: cleared on entry to a wait state, counts while waiting
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wdog <= 24'd0;
        end else if (!w_wait_state) begin
            r_wdog <= 24'd0;
        end else begin
            r_wdog <= r_wdog + 24'd1;
        end
    end

    // Capture the granted request and remember who was served last
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_last_grant <= 1'b1;
            r_owner      <= 1'b0;
            r_flash_addr <= 23'd0;
            r_mem_addr   <= 16'd0;
            r_count      <= 16'd0;
        end else if (w_grant_vld) begin
            r_last_grant <= w_grant_id;
            r_owner      <= w_grant_id;
            r_flash_addr <= w_grant_id ? req1_flash_addr : req0_flash_addr;
            r_mem_addr   <= w_grant_id ? req1_mem_addr   : req0_mem_addr;
            r_count      <= w_grant_id ? req1_count      : req0_count;
        end
    end

    // Output decode from the state register; everything held low in reset
    always_comb begin
        FL_WR       = 1'b0;
        FL_ADDRESS  = 4'd0;
        FL_DATA_OUT = 16'd0;
        done0       = 1'b0;
        done1       = 1'b0;
        busy        = (r_state != S_IDLE);
        fault       = (r_state == S_FAULT);
        req0_ready  = w_grant_vld && !w_grant_id;
        req1_ready  = w_grant_vld &&  w_grant_id;
        case (r_state)
            S_WAKE_WR: begin
                FL_WR = 1'b1; FL_ADDRESS = 4'd2; FL_DATA_OUT = 16'h0002;
            end
            S_WR_ALO: begin
                FL_WR = 1'b1; FL_ADDRESS = 4'd0; FL_DATA_OUT = r_flash_addr[15:0];
            end
            S_WR_AHI: begin
                FL_WR = 1'b1; FL_ADDRESS = 4'd1; FL_DATA_OUT = {9'd0, r_flash_addr[22:16]};
            end
            S_WR_DMAA: begin
                FL_WR = 1'b1; FL_ADDRESS = 4'd5; FL_DATA_OUT = r_mem_addr;
            end
            S_WR_DMAC: begin
                FL_WR = 1'b1; FL_ADDRESS = 4'd6; FL_DATA_OUT = r_count;
            end
            S_WR_GO: begin
                FL_WR = 1'b1; FL_ADDRESS = 4'd2; FL_DATA_OUT = 16'h0001;
            end
            S_COMPLETE: begin
                done0 = !r_owner;
                done1 =  r_owner;
            end
            default: ;
        endcase
        if (RST) begin
            FL_WR       = 1'b0;
            FL_ADDRESS  = 4'd0;
            FL_DATA_OUT = 16'd0;
            done0       = 1'b0;
            done1       = 1'b0;
            busy        = 1'b0;
            fault       = 1'b0;
            req0_ready  = 1'b0;
            req1_ready  = 1'b0;
        end
    end

endmodule

// File: tb/tb_flash_load_scheduler.sv
// Bench for flash_load_scheduler: transaction-level reference (arbitration by
// last-grant rule, expected register-write list per request, IRQ/timeout
// windows) compared against all DUT outputs every cycle.
module tb_flash_load_scheduler;

    localparam int unsigned TMO = 16;

    logic        CLK = 1'b0;
    logic        RST;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [22:0] req0_flash_addr, req1_flash_addr;
    logic [15:0] req0_mem_addr, req1_mem_addr;
    logic [15:0] req0_count, req1_count;
    logic        done0, done1, busy, fault;
    logic [3:0]  FL_ADDRESS;
    logic [15:0] FL_DATA_OUT;
    logic        FL_WR;
    logic        FL_IRQ;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_last;

    always #5 CLK = ~CLK;

    flash_load_scheduler #(
        .WAKE_ON_RESET (1),
        .TIMEOUT_CYCLES(24'(TMO))
    ) dut (
        .CLK(CLK), .RST(RST),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_flash_addr(req0_flash_addr), .req0_mem_addr(req0_mem_addr), .req0_count(req0_count),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_flash_addr(req1_flash_addr), .req1_mem_addr(req1_mem_addr), .req1_count(req1_count),
        .done0(done0), .done1(done1), .busy(busy), .fault(fault),
        .FL_ADDRESS(FL_ADDRESS), .FL_DATA_OUT(FL_DATA_OUT), .FL_WR(FL_WR), .FL_IRQ(FL_IRQ)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] obs();
        return {5'd0, busy, fault, done1, done0, req1_ready, req0_ready,
                FL_WR, FL_ADDRESS, FL_DATA_OUT};
    endfunction

    function automatic logic [31:0] exp_vec(input logic b, input logic f, input logic d1,
                                            input logic d0, input logic r1, input logic r0,
                                            input logic wr, input logic [3:0] a,
                                            input logic [15:0] d);
        return {5'd0, b, f, d1, d0, r1, r0, wr, a, d};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic smp();
        @(negedge CLK);
    endtask

    // Hold reset for n cycles; leaves the bench in cycle 1 after release
    task automatic do_reset(input int n);
        RST    = 1'b1;
        FL_IRQ = 1'b0;
        for (int i = 0; i < n; i++) begin
            smp();
            check_eq("reset_outputs", obs(), 32'd0);
            tick();
        end
        RST      = 1'b0;
        exp_last = 1;
    endtask

    // Wake write then dly WAKE_WAIT cycles, IRQ in the last one
    task automatic wake(input int dly);
        smp();
        check_eq("wake_write", obs(), exp_vec(1, 0, 0, 0, 0, 0, 1, 4'd2, 16'h0002));
        tick();
        for (int j = 1; j <= dly; j++) begin
            FL_IRQ = (j == dly);
            smp();
            check_eq("wake_wait", obs(), exp_vec(1, 0, 0, 0, 0, 0, 0, 4'd0, 16'd0));
            tick();
        end
        FL_IRQ = 1'b0;
    endtask

    task automatic idle(input int n);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            FL_IRQ = 1'($urandom_range(0, 1));
            smp();
            check_eq("idle", obs(), 32'd0);
            tick();
        end
        FL_IRQ = 1'b0;
    endtask

    // One request from an IDLE cycle. dly=0: no IRQ (expect watchdog fault).
    // abort_k>=0: assert reset in that programming cycle and stop.
    task automatic xfer(input logic [22:0] fa0, input logic [15:0] ma0, input logic [15:0] c0,
                        input logic [22:0] fa1, input logic [15:0] ma1, input logic [15:0] c1,
                        input logic v0, input logic v1, input int dly, input int abort_k,
                        input logic spur);
        int          g;
        logic [22:0] fa;
        logic [15:0] ma, c, wd;
        logic [3:0]  wa;
        req0_valid = v0; req0_flash_addr = fa0; req0_mem_addr = ma0; req0_count = c0;
        req1_valid = v1; req1_flash_addr = fa1; req1_mem_addr = ma1; req1_count = c1;
        if (v0 && v1) g = (exp_last == 1) ? 0 : 1;
        else          g = v1 ? 1 : 0;
        fa = (g == 1) ? fa1 : fa0;
        ma = (g == 1) ? ma1 : ma0;
        c  = (g == 1) ? c1  : c0;
        smp();
        check_eq("accept", obs(), exp_vec(0, 0, 0, 0, g == 1, g == 0, 0, 4'd0, 16'd0));
        tick();
        exp_last = g;
        // The served client immediately posts a different request
        if (g == 0) begin
            req0_flash_addr = ~fa; req0_mem_addr = ~ma; req0_count = ~c; req0_valid = 1'b1;
        end else begin
            req1_flash_addr = ~fa; req1_mem_addr = ~ma; req1_count = ~c; req1_valid = 1'b1;
        end
        for (int k = 0; k < 5; k++) begin
            case (k)
                0:       begin wa = 4'd0; wd = fa[15:0]; end
                1:       begin wa = 4'd1; wd = {9'd0, fa[22:16]}; end
                2:       begin wa = 4'd5; wd = ma; end
                3:       begin wa = 4'd6; wd = c; end
                default: begin wa = 4'd2; wd = 16'h0001; end
            endcase
            FL_IRQ = spur && (k == 1);
            if (k == abort_k) begin
                RST    = 1'b1;
                FL_IRQ = 1'b0;
                smp();
                check_eq("abort_outputs", obs(), 32'd0);
                tick();
                return;
            end
            smp();
            check_eq("prog_write", obs(), exp_vec(1, 0, 0, 0, 0, 0, 1, wa, wd));
            tick();
        end
        FL_IRQ = 1'b0;
        if (dly == 0) begin
            for (int j = 1; j <= int'(TMO); j++) begin
                smp();
                check_eq("wait_no_irq", obs(), exp_vec(1, 0, 0, 0, 0, 0, 0, 4'd0, 16'd0));
                tick();
            end
            smp();
            check_eq("fault_entry", obs(), exp_vec(1, 1, 0, 0, 0, 0, 0, 4'd0, 16'd0));
            tick();
            return;
        end
        for (int j = 1; j <= dly; j++) begin
            FL_IRQ = (j == dly);
            smp();
            check_eq("wait_irq", obs(), exp_vec(1, 0, 0, 0, 0, 0, 0, 4'd0, 16'd0));
            tick();
        end
        FL_IRQ = 1'b0;
        smp();
        check_eq("complete", obs(), exp_vec(1, 0, g == 1, g == 0, 0, 0, 0, 4'd0, 16'd0));
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        RST = 1'b1; FL_IRQ = 1'b0;
        req0_valid = 1'b1; req0_flash_addr = 23'h123456; req0_mem_addr = 16'h8000; req0_count = 16'd3;
        req1_valid = 1'b0; req1_flash_addr = 23'd0; req1_mem_addr = 16'd0; req1_count = 16'd0;
        exp_last = 1;

        // Reset, wake with req0 held, then the directed single request
        do_reset(3);
        wake(5);
        xfer(23'h123456, 16'h8000, 16'h0003, 23'd0, 16'd0, 16'd0, 1'b1, 1'b0, 14, -1, 1'b0);
        idle(2);

        // Watchdog fault: no IRQ, then requests and IRQs are ignored
        xfer(23'($urandom), 16'($urandom), 16'($urandom), 23'd0, 16'd0, 16'd0,
             1'b1, 1'b0, 0, -1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            req0_valid = 1'b1; req1_valid = 1'b1;
            FL_IRQ = 1'($urandom_range(0, 1));
            smp();
            check_eq("fault_hold", obs(), exp_vec(1, 1, 0, 0, 0, 0, 0, 4'd0, 16'd0));
            tick();
        end
        do_reset(2);
        wake(4);

        // Both clients valid back to back: round-robin from last_grant=1
        for (int i = 0; i < 4; i++)
            xfer(23'($urandom), 16'($urandom), 16'($urandom),
                 23'($urandom), 16'($urandom), 16'($urandom),
                 1'b1, 1'b1, int'($urandom_range(1, TMO)), -1, 1'b1);

        // Reset during WR_DMAA, then IRQs exactly at the timeout boundary
        xfer(23'($urandom), 16'($urandom), 16'($urandom), 23'd0, 16'd0, 16'd0,
             1'b1, 1'b0, 5, 2, 1'b0);
        do_reset(1);
        wake(int'(TMO));
        xfer(23'($urandom), 16'($urandom), 16'($urandom),
             23'($urandom), 16'($urandom), 16'($urandom),
             1'b0, 1'b1, int'(TMO), -1, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            logic v0, v1;
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
            v0 = 1'($urandom_range(0, 1));
            v1 = v0 ? 1'($urandom_range(0, 1)) : 1'b1;
            xfer(23'($urandom), 16'($urandom), 16'($urandom),
                 23'($urandom), 16'($urandom), 16'($urandom),
                 v0, v1, int'($urandom_range(1, TMO)), -1, 1'($urandom_range(0, 1)));
        end
        idle(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
